// File: rtl/simm_dramctl_if.sv
// 68030 bus side of the SIMM DRAM controller: strobes, size, address in;
// DSACK/BERR termination drives out.
interface simm_dramctl_if;
    logic        nCS;
    logic        RnW;
    logic        nAS;
    logic        nDS;
    logic        SIZ0;
    logic        SIZ1;
    logic [27:0] ADDR;
    logic        DSACK0;
    logic        DSACK1;
    logic        BERR;

    modport master (
        output nCS, RnW, nAS, nDS, SIZ0, SIZ1, ADDR,
        input  DSACK0, DSACK1, BERR
    );

    modport slave (
        input  nCS, RnW, nAS, nDS, SIZ0, SIZ1, ADDR,
        output DSACK0, DSACK1, BERR
    );
endinterface

// File: rtl/simm_dramctl.sv
// FPM DRAM controller for the Playground 68030: 1..2 SIMMs, 1..2 RAS banks each.
// Registered RAS/CAS/address/WE sequencing, 32-bit DSACK termination, BERR for
// unpopulated space, CAS-before-RAS refresh with a small request queue.
module simm_dramctl #(
    parameter int NUM_SIMMS   = 2,
    parameter int SIDES       = 2,
    parameter int ROW_BITS    = 12,
    parameter int COL_BITS    = 12,
    parameter int REFRESH_CNT = 375,
    parameter int TRP_CYCLES  = 2
) (
    input  logic                         CLK,
    input  logic                         nRST,
    simm_dramctl_if.slave                bus,
    output logic                         DRAM_nWR,
    output logic [11:0]                  DRAM_ADDR,
    output logic [NUM_SIMMS*SIDES-1:0]   DRAM_nRAS,
    output logic [3:0]                   DRAM_nCAS
);
    localparam int NUM_BANKS = NUM_SIMMS * SIDES;
    localparam int B         = $clog2(NUM_BANKS);
    localparam int BW        = (B > 0) ? B : 1;
    localparam int TOP       = 2 + COL_BITS + ROW_BITS + B;
    localparam int RCW       = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam int PCW       = (TRP_CYCLES > 1) ? $clog2(TRP_CYCLES) : 1;
    localparam logic [11:0] ROW_MASK = 12'((33'd1 << ROW_BITS) - 33'd1);
    localparam logic [11:0] COL_MASK = 12'((33'd1 << COL_BITS) - 33'd1);

    typedef enum logic [3:0] {
        IDLE, ROW, RAS, COL, CAS, ACK, BERR_ST,
        REF1, REF2, REF3, REF4, PRE
    } state_t;

    state_t                 state, state_n;
    logic [PCW-1:0]         pre_cnt, pre_cnt_n;
    logic [RCW-1:0]         ref_cnt;
    logic [1:0]             pending;
    logic [27:0]            acc_addr, acc_addr_n;
    logic                   acc_rnw, acc_rnw_n;
    logic [1:0]             acc_siz, acc_siz_n;

    logic                   nwr_n;
    logic [11:0]            addr_n;
    logic [NUM_BANKS-1:0]   nras_n;
    logic [3:0]             ncas_n;
    logic                   dsack_n, dsack_q;
    logic                   berr_n, berr_q;

    logic                   wrap, ref_req, acc_req, oor, decide, enter_ref;
    logic [27:0]            row_sh, bank_sh;
    logic [BW-1:0]          bank;
    logic [NUM_BANKS-1:0]   ras_sel;
    logic [11:0]            row_a, col_a;

    // 68030 byte lanes (bit3 = D31..24) for the latched size and A1:A0
    function automatic logic [3:0] byte_en(input logic rnw, input logic [1:0] siz,
                                           input logic [1:0] a);
        logic [3:0] be;
        be = 4'b1111;
        if (!rnw) begin
            case (siz)
                2'b01:   be = 4'b1000 >> a;
                2'b10:   be = (a == 2'd0) ? 4'b1100 : (a == 2'd1) ? 4'b0110 :
                              (a == 2'd2) ? 4'b0011 : 4'b0001;
                2'b11:   be = (a == 2'd0) ? 4'b1110 : (a == 2'd1) ? 4'b0111 :
                              (a == 2'd2) ? 4'b0011 : 4'b0001;
                default: be = (a == 2'd0) ? 4'b1111 : (a == 2'd1) ? 4'b0111 :
                              (a == 2'd2) ? 4'b0011 : 4'b0001;
            endcase
        end
        return be;
    endfunction

    // A wrap in the same cycle as IDLE counts as a request so refresh beats a
    // simultaneous access; out-of-range is judged on the live bus address.
    assign wrap    = (ref_cnt == RCW'(REFRESH_CNT - 1));
    assign ref_req = wrap | (pending != 2'd0);
    assign acc_req = ~bus.nCS & ~bus.nAS;
    assign oor     = |(bus.ADDR >> TOP);

    assign row_sh  = acc_addr >> (2 + COL_BITS);
    assign bank_sh = acc_addr >> (2 + COL_BITS + ROW_BITS);
    assign row_a   = row_sh[11:0] & ROW_MASK;
    assign col_a   = acc_addr[13:2] & COL_MASK;
    assign bank    = (B == 0) ? '0 : bank_sh[BW-1:0];
    assign ras_sel = NUM_BANKS'(1) << bank;

    assign bus.DSACK0 = dsack_q;
    assign bus.DSACK1 = dsack_q;
    assign bus.BERR   = berr_q;

    // Next state and next registered pin values; pins hold unless a state acts
    always_comb begin
        state_n    = state;
        pre_cnt_n  = pre_cnt;
        acc_addr_n = acc_addr;
        acc_rnw_n  = acc_rnw;
        acc_siz_n  = acc_siz;
        nwr_n      = DRAM_nWR;
        addr_n     = DRAM_ADDR;
        nras_n     = DRAM_nRAS;
        ncas_n     = DRAM_nCAS;
        dsack_n    = dsack_q;
        berr_n     = berr_q;
        decide     = 1'b0;

        case (state)
            IDLE:    decide = 1'b1;
            ROW: begin
                addr_n  = row_a;
                state_n = RAS;
            end
            RAS: begin
                nras_n  = ~ras_sel;
                state_n = COL;
            end
            COL: begin
                addr_n  = col_a;
                nwr_n   = acc_rnw;
                state_n = CAS;
            end
            CAS: begin
                ncas_n  = ~byte_en(acc_rnw, acc_siz, acc_addr[1:0]);
                state_n = ACK;
            end
            ACK: begin
                if (bus.nAS) state_n = PRE;
                else         dsack_n = 1'b1;
            end
            BERR_ST: begin
                if (bus.nAS) state_n = PRE;
                else         berr_n  = 1'b1;
            end
            REF1: begin
                nwr_n   = 1'b1;
                ncas_n  = 4'h0;
                state_n = REF2;
            end
            REF2: begin
                nras_n  = '0;
                state_n = REF3;
            end
            REF3: begin
                ncas_n  = 4'hF;
                state_n = REF4;
            end
            REF4:    state_n = PRE;
            PRE: begin
                // the last precharge cycle makes the IDLE decision itself so a
                // waiting access or queued refresh does not lose a cycle
                if (pre_cnt == PCW'(TRP_CYCLES - 1)) decide    = 1'b1;
                else                                 pre_cnt_n = pre_cnt + PCW'(1);
            end
            default: state_n = IDLE;
        endcase

        if (decide) begin
            if (ref_req) begin
                state_n = REF1;
            end else if (acc_req) begin
                acc_addr_n = bus.ADDR;
                acc_rnw_n  = bus.RnW;
                acc_siz_n  = {bus.SIZ1, bus.SIZ0};
                state_n    = oor ? BERR_ST : ROW;
            end else begin
                state_n = IDLE;
            end
        end

        // everything is released on the way into precharge
        if (state_n == PRE && state != PRE) begin
            pre_cnt_n = '0;
            nras_n    = '1;
            ncas_n    = 4'hF;
            nwr_n     = 1'b1;
            addr_n    = '0;
            dsack_n   = 1'b0;
            berr_n    = 1'b0;
        end
    end

    assign enter_ref = (state_n == REF1);

    // State, latched request and registered DRAM/bus pins
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            acc_addr  <= '0;
            acc_rnw   <= 1'b1;
            acc_siz   <= 2'b00;
            DRAM_nWR  <= 1'b1;
            DRAM_ADDR <= '0;
            DRAM_nRAS <= '1;
            DRAM_nCAS <= 4'hF;
            dsack_q   <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state     <= state_n;
            pre_cnt   <= pre_cnt_n;
            acc_addr  <= acc_addr_n;
            acc_rnw   <= acc_rnw_n;
            acc_siz   <= acc_siz_n;
            DRAM_nWR  <= nwr_n;
            DRAM_ADDR <= addr_n;
            DRAM_nRAS <= nras_n;
            DRAM_nCAS <= ncas_n;
            dsack_q   <= dsack_n;
            berr_q    <= berr_n;
        end
    end

    // Refresh interval counter and saturating queue of pending refreshes
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ref_cnt <= '0;
            pending <= 2'd0;
        end else begin
            ref_cnt <= wrap ? '0 : ref_cnt + RCW'(1);
            case ({wrap, enter_ref})
                2'b10:   if (pending != 2'd3) pending <= pending + 2'd1;
                2'b01:   pending <= pending - 2'd1;
                default: pending <= pending;
            endcase
        end
    end
endmodule
